// File: rtl/serial_subtract_controller.sv
// serial_subtract_controller: bit-serial two's-complement subtract/add, one bit per cycle, LSB first.
module serial_subtract_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a, r_b, r_shift;
  logic             r_op, r_c;
  logic [CW-1:0]    r_cnt;
  logic             w_a, w_b, w_bit, w_cout, w_ovf, w_last;
  logic [WIDTH-1:0] w_shift;
  assign w_a     = r_a[r_cnt];
  assign w_b     = r_b[r_cnt];
  assign w_bit   = w_a ^ w_b ^ r_c;
  assign w_cout  = r_op ? (w_a & w_b) | (r_c & (w_a ^ w_b)) : (~w_a & w_b) | (~(w_a ^ w_b) & r_c);
  assign w_shift = {w_bit, r_shift[WIDTH-1:1]};
  assign w_last  = r_cnt == CW'(WIDTH - 1);
  // On the last bit w_bit is the result sign, so overflow is resolved in the same cycle.
  assign w_ovf   = (r_op ? (r_a[WIDTH-1] == r_b[WIDTH-1]) : (r_a[WIDTH-1] != r_b[WIDTH-1]))
                   && (w_bit != r_a[WIDTH-1]);
  assign busy    = r_state != S_IDLE;
  assign done    = r_state == S_DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 1'b0;
      r_c        <= 1'b0;
      r_cnt      <= '0;
      r_shift    <= '0;
      result     <= '0;
      overflow   <= 1'b0;
      borrow_out <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_state <= S_RUN;
        r_a     <= a_in;
        r_b     <= b_in;
        r_op    <= op;
        r_c     <= 1'b0;
        r_cnt   <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_shift <= w_shift;
      r_c     <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_state    <= S_DONE;
        result     <= w_shift;
        overflow   <= w_ovf;
        borrow_out <= w_cout;
      end
    end else begin
      r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_serial_subtract_controller.sv
// tb_serial_subtract_controller: directed scenario tasks with hand-computed expectations.
module tb_serial_subtract_controller;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, op = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic       busy, done, overflow, borrow_out;
  logic [7:0] result;
  int         n_pass = 0, n_total = 0;
  serial_subtract_controller #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .borrow_out(borrow_out)
  );
  always #5 clk = ~clk;
  // lat counts falling edges from driving start until done is seen (9 = WIDTH+1).
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic o, output int lat);
    @(negedge clk); a_in = a; b_in = b; op = o; start = 1'b1; lat = 0;
    @(negedge clk); start = 1'b0; lat = 1;
    while (!done && lat < 30) begin @(negedge clk); lat++; end
  endtask
  task automatic test_reset;
    rst = 1'b1; start = 1'b1; a_in = 8'h44; b_in = 8'h11;
    @(negedge clk); @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    n_total++; if (result !== 8'h00) $display("FAIL reset_result got %h exp 00", result); else n_pass++;
    n_total++; if ({overflow, borrow_out} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {overflow, borrow_out}); else n_pass++;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b exp 0", busy); else n_pass++;
  endtask
  task automatic test_op(input string nm, input logic [7:0] a, input logic [7:0] b, input logic o,
                         input logic [7:0] e_res, input logic e_ovf, input logic e_bout);
    int lat;
    do_op(a, b, o, lat);
    n_total++; if (lat !== 9) $display("FAIL %s_latency got %0d exp 9", nm, lat); else n_pass++;
    n_total++; if (result !== e_res) $display("FAIL %s_result got %h exp %h", nm, result, e_res); else n_pass++;
    n_total++; if (overflow !== e_ovf) $display("FAIL %s_overflow got %b exp %b", nm, overflow, e_ovf); else n_pass++;
    n_total++; if (borrow_out !== e_bout) $display("FAIL %s_borrow got %b exp %b", nm, borrow_out, e_bout); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL %s_busy_done got %b exp 1", nm, busy); else n_pass++;
    @(negedge clk);
    n_total++; if ({busy, done} !== 2'b00) $display("FAIL %s_after_done got %b exp 00", nm, {busy, done}); else n_pass++;
    n_total++; if (result !== e_res) $display("FAIL %s_held got %h exp %h", nm, result, e_res); else n_pass++;
  endtask
  task automatic test_reset_abort;
    int lat, seen;
    @(negedge clk); a_in = 8'h55; b_in = 8'h11; op = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (result !== 8'h00) $display("FAIL abort_result got %h exp 00", result); else n_pass++;
    seen = 0;
    repeat (12) begin if (done) seen++; @(negedge clk); end
    n_total++; if (seen !== 0) $display("FAIL abort_no_done got %0d pulses exp 0", seen); else n_pass++;
    do_op(8'h10, 8'h01, 1'b0, lat);
    n_total++; if (lat !== 9) $display("FAIL abort_next_latency got %0d exp 9", lat); else n_pass++;
    n_total++; if (result !== 8'h0F) $display("FAIL abort_next_result got %h exp 0f", result); else n_pass++;
  endtask
  task automatic test_ignore_start;
    int lat;
    @(negedge clk); a_in = 8'h20; b_in = 8'h05; op = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 1;
    repeat (2) begin @(negedge clk); lat++; end
    a_in = 8'hFF; b_in = 8'hFF; op = 1'b1; start = 1'b1;
    while (!done && lat < 30) begin @(negedge clk); lat++; end
    start = 1'b0;
    n_total++; if (lat !== 9) $display("FAIL ignore_latency got %0d exp 9", lat); else n_pass++;
    n_total++; if (result !== 8'h1B) $display("FAIL ignore_result got %h exp 1b", result); else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL ignore_busy_low got %b exp 0", busy); else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL ignore_no_queue got %b exp 0", busy); else n_pass++;
  endtask
  task automatic test_back_to_back;
    int lat;
    do_op(8'h09, 8'h04, 1'b1, lat);
    n_total++; if (result !== 8'h0D) $display("FAIL b2b_first got %h exp 0d", result); else n_pass++;
    do_op(8'hC0, 8'h50, 1'b0, lat);
    n_total++; if (lat !== 9) $display("FAIL b2b_latency got %0d exp 9", lat); else n_pass++;
    n_total++; if ({result, overflow, borrow_out} !== {8'h70, 1'b1, 1'b0}) $display("FAIL b2b_second got %h/%b/%b exp 70/1/0", result, overflow, borrow_out); else n_pass++;
  endtask
  initial begin
    test_reset;
    test_op("sub_basic", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    test_op("sub_neg",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b1);
    test_op("sub_ovf",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b0);
    test_op("add_ovf",   8'h7F, 8'h01, 1'b1, 8'h80, 1'b1, 1'b0);
    test_op("add_wrap",  8'hFF, 8'h01, 1'b1, 8'h00, 1'b0, 1'b1);
    test_op("add_negov", 8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1);
    test_reset_abort;
    test_ignore_start;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/serial_subtract_controller.md
SERIAL_SUBTRACT_CONTROLLER -- requirements
Module: serial_subtract_controller

Interface
REQ-001 Parameter SHALL be: WIDTH, default 8 (min 2), operand/result width in bits.
REQ-002 Port SHALL be: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port SHALL be: rst  input  1  synchronous, active-high reset.
REQ-004 Port SHALL be: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 Port SHALL be: op  input  1  0 = a-b, 1 = a+b; captured with start.
REQ-006 Port SHALL be: a_in  input  WIDTH  two's-complement minuend/addend; captured with start.
REQ-007 Port SHALL be: b_in  input  WIDTH  two's-complement subtrahend/addend; captured with start.
REQ-008 Port SHALL be: busy  output  1  high in RUN and DONE.
REQ-009 Port SHALL be: done  output  1  one-cycle pulse, result valid.
REQ-010 Port SHALL be: result  output  WIDTH  two's-complement result.
REQ-011 Port SHALL be: overflow  output  1  signed overflow of last operation.
REQ-012 Port SHALL be: borrow_out  output  1  final borrow (sub) or carry (add) out of MSB.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE with start=1 SHALL capture a_in, b_in, op; clear bit counter and borrow/carry flop to 0; go to RUN.
REQ-015 IDLE with start=0 SHALL stay in IDLE, outputs held.
REQ-016 RUN SHALL process one bit per cycle, LSB first, through a single internal one-bit slice.
REQ-017 Sub slice SHALL be: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
REQ-018 Add slice SHALL be: s = a^b^cin; cout = (a&b) | (cin&(a^b)).
REQ-019 Each RUN cycle SHALL shift the result register right by one, inserting the slice bit at the MSB, and register the new borrow/carry.
REQ-020 RUN SHALL last exactly WIDTH cycles; counter == WIDTH-1 SHALL transition to DONE.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 Latency: done SHALL be high exactly WIDTH+1 cycles after the start-accepting edge; next start is accepted earliest in the cycle after done (one operation per WIDTH+2 cycles).
REQ-023 Sub overflow SHALL be: sign(a) != sign(b) and sign(result) != sign(a).
REQ-024 Add overflow SHALL be: sign(a) == sign(b) and sign(result) != sign(a).
REQ-025 result, overflow and borrow_out SHALL be updated at entry to DONE and held until the next start is accepted.
REQ-026 start in RUN or DONE SHALL be ignored; no queueing.
REQ-027 Changes to a_in, b_in, op after capture SHALL NOT affect the operation in progress.
REQ-028 result SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, and busy=0, done=0, result=0, overflow=0, borrow_out=0, counter=0, borrow flop=0.
REQ-030 rst SHALL take priority over start in the same cycle.
REQ-031 rst during RUN or DONE SHALL abort the operation with no done pulse; the next start after rst deasserts SHALL operate normally.

Verification (WIDTH=8)
REQ-032 a=0x05, b=0x03, op=0 -> done 9 cycles after accept; result=0x02, overflow=0, borrow_out=0.
REQ-033 a=0x03, b=0x05, op=0 -> result=0xFE, overflow=0, borrow_out=1.
REQ-034 a=0x80, b=0x01, op=0 -> result=0x7F, overflow=1, borrow_out=0.
REQ-035 a=0x7F, b=0x01, op=1 -> result=0x80, overflow=1, borrow_out=0.
REQ-036 rst pulsed on 4th RUN cycle -> next cycle busy=0, result=0, and no done; then a=0x10, b=0x01, op=0 -> result=0x0F.
REQ-037 start re-asserted and a_in/b_in changed during RUN -> ignored; original result delivered; busy low exactly one cycle after done.
